// File: rtl/center_arbiter.sv
// center_arbiter: round-robin share of one DW-bit capture register among N_REQ requesters.
// Latency: Grant_Id 1 cycle after Req, Dout_Valid for HOLD_CYCLES, then a 1-cycle Ack.
// Backpressure: Req is held until Ack; dropping it aborts. CENTER_ARB_LOCK_EN adds Lock.
module center_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DW          = 4,
   parameter int HOLD_CYCLES = 2,
   localparam int IW         = $clog2(N_REQ)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_REQ-1:0]    Req,
   input  logic [N_REQ*DW-1:0] Din,
`ifdef CENTER_ARB_LOCK_EN
   input  logic [N_REQ-1:0]    Lock,
`endif
   output logic [N_REQ-1:0]    Ack,
   output logic [DW-1:0]       Dout,
   output logic                Dout_Valid,
   output logic [IW-1:0]       Grant_Id,
   output logic                Busy
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     gid_q, gid_d;
   logic [DW-1:0]     dout_q, dout_d;
   logic              vld_q, vld_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [DW-1:0]     din_arr [N_REQ];
   logic              found;
   logic [IW-1:0]     sel;
   logic [IW-1:0]     idx;
   logic              req_g;
   logic              relock;

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign din_arr[i] = Din[i*DW +: DW];
   end

   assign req_g = Req[gid_q];

`ifdef CENTER_ARB_LOCK_EN
   assign relock = Lock[gid_q] & req_g;
`else
   assign relock = 1'b0;
`endif

   // Search starts one past the last grantee so every other requester goes first.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = IW'((int'(ptr_q) + i) % N_REQ);
         if (!found && Req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      vld_d   = 1'b0;
      ack_d   = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gid_d   = sel;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (req_g) begin
               dout_d  = din_arr[gid_q];
               cnt_d   = CW'(HOLD_CYCLES - 1);
               vld_d   = 1'b1;
               state_d = HOLD;
            end else begin
               ptr_d   = gid_q;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (!req_g) begin
               ptr_d   = gid_q;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               ack_d[gid_q] = 1'b1;
               state_d      = RELEASE;
            end else begin
               cnt_d   = cnt_q - 1'b1;
               vld_d   = 1'b1;
            end
         end
         RELEASE: begin
            // A locked requester is re-granted without moving the pointer.
            if (relock) begin
               state_d = GRANT;
            end else begin
               ptr_d   = gid_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= IW'(N_REQ - 1);
         gid_q   <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Ack        = ack_q;
   assign Dout       = dout_q;
   assign Dout_Valid = vld_q;
   assign Grant_Id   = gid_q;
   assign Busy       = busy_q;

endmodule
